// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if -- data-memory bus between the MEM pipeline stage and data memory.
//
// Signals (direction as seen by the master, i.e. the pipeline stage):
//   dmem_req    out  request valid; held with its fields until dmem_gnt
//   dmem_we     out  1 = write, 0 = read
//   dmem_addr   out  N  word-aligned byte address
//   dmem_be     out  4  byte enables
//   dmem_wdata  out  N  lane-replicated store data
//   dmem_gnt    in   request accepted this cycle
//   dmem_rvalid in   read data valid (never in the same cycle as its gnt)
//   dmem_rdata  in   N  read data
//
// Modports: master (pipeline stage), slave (memory / memory model).
// -----------------------------------------------------------------------------
interface mem_stage_if #(
   parameter int N = 32
);
   logic         dmem_req;
   logic         dmem_we;
   logic [N-1:0] dmem_addr;
   logic [3:0]   dmem_be;
   logic [N-1:0] dmem_wdata;
   logic         dmem_gnt;
   logic         dmem_rvalid;
   logic [N-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access pipeline stage between EX/MEM and writeback.
//
// Accepts one instruction at a time from EX/MEM. Non-memory instructions pass
// straight into the MEM/WB registers (1-cycle latency). Loads and stores are
// latched and issued on the data-memory bus (req/gnt, then rvalid for loads);
// upstream is stalled (in_ready=0) until the access completes. Load data is
// lane-selected and sign/zero extended before it is registered.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   EX/MEM handshake; in_ready low = stall upstream
//   memRead, memWrite   load / store flags (both set = load, store suppressed)
//   funct3              access size and signedness
//   ALUres              ALU result / effective address
//   store_data          rs2 value for stores
//   NPCin, regDest_in, mem2reg_in, regWrite_in   payload forwarded to WB
//   dmem                data-memory bus (mem_stage_if.master)
//   wb_valid            1-cycle pulse per completed instruction
//   ALUres_out, MEMread_out, NPC_out, regDest_out, mem2reg_out
//                       registered MEM/WB payload
//   regWrite_out        register write enable, qualified by wb_valid
//   misalign            misaligned-access flag, valid with wb_valid
//
// Build option: define MEM_MISALIGN_TRAP_EN to turn misaligned half/word
// accesses into a 1-cycle no-op completion with misalign=1 and no register
// write. Without it, misalign is tied low and low address bits only select
// lanes.
//
// Byte-lane logic assumes N = 32.
// -----------------------------------------------------------------------------
module mem_stage #(
   parameter int N    = 32,
   parameter int RD_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            memRead,
   input  logic            memWrite,
   input  logic [2:0]      funct3,
   input  logic [N-1:0]    ALUres,
   input  logic [N-1:0]    store_data,
   input  logic [N-1:0]    NPCin,
   input  logic [RD_W-1:0] regDest_in,
   input  logic [1:0]      mem2reg_in,
   input  logic            regWrite_in,
   mem_stage_if.master     dmem,
   output logic            wb_valid,
   output logic [N-1:0]    ALUres_out,
   output logic [N-1:0]    MEMread_out,
   output logic [N-1:0]    NPC_out,
   output logic [RD_W-1:0] regDest_out,
   output logic [1:0]      mem2reg_out,
   output logic            regWrite_out,
   output logic            misalign
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   // Payload travelling to writeback
   typedef struct packed {
      logic [N-1:0]    alu;
      logic [N-1:0]    npc;
      logic [RD_W-1:0] rd;
      logic [1:0]      m2r;
      logic            rw;
   } payload_t;

   // Select the addressed byte/half of a read word and extend it.
   function automatic logic [N-1:0] fmt_load(input logic [N-1:0] rdat,
                                             input logic [2:0]   f3,
                                             input logic [1:0]   off);
      logic [3:0][7:0] lane;
      logic [7:0]      b;
      logic [15:0]     h;
      logic [N-1:0]    r;
      lane = rdat[31:0];
      b    = lane[off];
      h    = off[1] ? rdat[31:16] : rdat[15:0];
      case (f3)
         3'b000:  r = {{(N-8){b[7]}}, b};
         3'b100:  r = {{(N-8){1'b0}}, b};
         3'b001:  r = {{(N-16){h[15]}}, h};
         3'b101:  r = {{(N-16){1'b0}}, h};
         default: r = rdat;
      endcase
      return r;
   endfunction

   state_t       state_q, state_d;

   // Latched memory instruction
   payload_t     hold_q;
   logic         is_ld_q;
   logic         we_q;
   logic [N-1:0] addr_q;
   logic [3:0]   be_q;
   logic [N-1:0] wdata_q;
   logic [2:0]   f3_q;
   logic [1:0]   off_q;

   // MEM/WB registers
   payload_t     out_q;
   logic [N-1:0] memrd_q;
   logic         wb_valid_q;

   // Decode of the incoming instruction
   payload_t     pl_in;
   logic [1:0]   off_in;
   logic         mem_op_in;
   logic         st_in;
   logic         trap_in;
   logic [3:0]   be_in;
   logic [N-1:0] wdata_in;

   // FSM controls
   logic         capture;
   logic         src_in;
   logic         wb_d;
   logic         mis_d;
   logic [N-1:0] memrd_d;
   payload_t     pl_d;
   logic         req;

   assign pl_in     = {ALUres, NPCin, regDest_in, mem2reg_in, regWrite_in};
   assign off_in    = ALUres[1:0];
   assign mem_op_in = memRead | memWrite;
   // memRead wins when both flags are set
   assign st_in     = memWrite & ~memRead;

`ifdef MEM_MISALIGN_TRAP_EN
   // Half with odd offset, or word with any nonzero offset. funct3=101 is only a
   // half access for loads; as a store it is a full word, always aligned to lane 0.
   assign trap_in = mem_op_in &&
                    ((((funct3 == 3'b001) || (memRead && funct3 == 3'b101)) && off_in[0]) ||
                     ((funct3 == 3'b010) && (off_in != 2'b00)));
`else
   assign trap_in = 1'b0;
`endif

   // Store lane enables and replicated data; loads read the whole word.
   always_comb begin
      be_in    = 4'b1111;
      wdata_in = store_data;
      if (st_in) begin
         case (funct3)
            3'b000: begin
               be_in    = 4'b0001 << off_in;
               wdata_in = {4{store_data[7:0]}};
            end
            3'b001: begin
               be_in    = 4'b0011 << {off_in[1], 1'b0};
               wdata_in = {2{store_data[15:0]}};
            end
            default: ;
         endcase
      end
   end

   // Next-state and control
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      req      = 1'b0;
      capture  = 1'b0;
      src_in   = 1'b0;
      wb_d     = 1'b0;
      mis_d    = 1'b0;
      memrd_d  = '0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (!mem_op_in || trap_in) begin
                  wb_d   = 1'b1;
                  src_in = 1'b1;
                  mis_d  = trap_in;
               end else begin
                  capture = 1'b1;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            req = 1'b1;
            if (dmem.dmem_gnt) begin
               if (is_ld_q) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_IDLE;
                  wb_d    = 1'b1;
               end
            end
         end
         S_RESP: begin
            if (dmem.dmem_rvalid) begin
               state_d = S_IDLE;
               wb_d    = 1'b1;
               memrd_d = fmt_load(dmem.dmem_rdata, f3_q, off_q);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Payload written to MEM/WB; a trapped access never writes the register file
   always_comb begin
      pl_d    = src_in ? pl_in : hold_q;
      pl_d.rw = pl_d.rw & ~mis_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         hold_q     <= '0;
         is_ld_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         f3_q       <= '0;
         off_q      <= '0;
         out_q      <= '0;
         memrd_q    <= '0;
         wb_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wb_valid_q <= wb_d;
         if (capture) begin
            hold_q  <= pl_in;
            is_ld_q <= memRead;
            we_q    <= st_in;
            addr_q  <= {ALUres[N-1:2], 2'b00};
            be_q    <= be_in;
            wdata_q <= wdata_in;
            f3_q    <= funct3;
            off_q   <= off_in;
         end
         if (wb_d) begin
            out_q   <= pl_d;
            memrd_q <= memrd_d;
         end
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic misalign_q;
   always_ff @(posedge clk) begin
      if (rst) misalign_q <= 1'b0;
      else     misalign_q <= mis_d;
   end
   assign misalign = misalign_q;
`else
   assign misalign = 1'b0;
`endif

   assign dmem.dmem_req   = req;
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_be    = be_q;
   assign dmem.dmem_wdata = wdata_q;

   assign wb_valid     = wb_valid_q;
   assign ALUres_out   = out_q.alu;
   assign NPC_out      = out_q.npc;
   assign regDest_out  = out_q.rd;
   assign mem2reg_out  = out_q.m2r;
   assign regWrite_out = out_q.rw & wb_valid_q;
   assign MEMread_out  = memrd_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the EX/MEM register and the writeback stage.
- Issues load/store requests to data memory over a req/gnt/rvalid handshake.
- Aligns and sign/zero-extends load data.
- Registers the MEM/WB payload (ALU result, load data, NPC, destination, mem2reg, regWrite) that writeback consumes; stalls upstream while a memory access is outstanding.

Parameters:
- N, 32, datapath width; byte-lane logic fixed for N=32.
- RD_W, 6, register-destination width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX/MEM holds a valid instruction
- in_ready  out  1  stage can accept; low = stall upstream
- memRead  in  1  instruction is a load
- memWrite  in  1  instruction is a store
- funct3  in  3  access size/sign
- ALUres  in  N  ALU result / effective address
- store_data  in  N  rs2 value for stores
- NPCin  in  N  PC+4
- regDest_in  in  RD_W  destination register
- mem2reg_in  in  2  writeback select
- regWrite_in  in  1  register write enable
- dmem_req  out  1  memory request
- dmem_we  out  1  1=write
- dmem_addr  out  N  word-aligned address ({ALUres[N-1:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  N  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  N  read data
- wb_valid  out  1  MEM/WB payload valid (1-cycle pulse per instruction)
- ALUres_out, MEMread_out, NPC_out  out  N  registered payload
- regDest_out  out  RD_W
- mem2reg_out  out  2
- regWrite_out  out  1  qualified by wb_valid
- misalign  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset: FSM=IDLE, dmem_req=0, wb_valid=0, regWrite_out=0, misalign=0, all payload outputs 0, in_ready=1 from the first cycle after reset.
- FSM states:
  - IDLE: in_ready=1. On in_valid:
    - no memRead/memWrite: load payload regs next edge, wb_valid=1 (latency 1).
    - otherwise: latch the instruction, go to REQ.
  - REQ: dmem_req=1, in_ready=0, request fields stable until gnt.
    - On gnt with a store: go to IDLE, wb_valid=1 next cycle.
    - On gnt with a load: go to RESP.
  - RESP: dmem_req=0, in_ready=0. On rvalid: MEMread_out=formatted rdata, wb_valid=1, go to IDLE.
- Back-to-back: the completion cycle returns to IDLE; a new instruction is accepted in the following cycle.
- rvalid is never asserted in the same cycle as the corresponding gnt. rvalid outside RESP is ignored.
- memRead && memWrite: treated as a load; store suppressed.
- Loads, using off=addr[1:0]:
  - LB(000) / LBU(100): byte at lane off, sign/zero extended.
  - LH(001) / LHU(101): half at lane off[1], sign/zero extended.
  - LW(010) and any other funct3: full word.
- Stores:
  - SB: be=4'b0001<<off, wdata={4{byte}}.
  - SH: be=4'b0011<<{off[1],1'b0}, wdata={2{half}}.
  - SW / other funct3: be=4'b1111.
- Load requests use be=4'b1111.
- MEMread_out=0 for non-load instructions.
- Reset mid-access: immediate return to IDLE; dmem_req drops next edge; no wb_valid for the aborted instruction; late rvalid ignored.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with off[0]=1, or LW/SW with off!=0, issues no memory request. The stage completes in 1 cycle with wb_valid=1, regWrite_out=0, misalign=1 for that pulse.
- Undefined: misalign tied 0; low offset bits are ignored beyond lane selection (half uses off[1], word uses lane 0).

Test Plan:
- ALU op, ALUres=0x1234, regDest_in=5, regWrite_in=1, mem2reg_in=00 -> next cycle wb_valid=1, ALUres_out=0x1234, regDest_out=5, in_ready stays 1.
- LB addr=0x103, rdata=0x80FF_0000, gnt after 2 cycles, rvalid 1 cycle later -> be=1111, addr=0x100, MEMread_out=0xFFFF_FF80, in_ready low from accept until completion.
- LHU addr=0x202, rdata=0xBEEF_1234 -> MEMread_out=0x0000_BEEF; LH same -> 0xFFFF_BEEF.
- SB addr=0x301, store_data=0xAABB_CCDD, immediate gnt -> be=0010, wdata=0xDDDD_DDDD, wb_valid 1 cycle after gnt, MEMread_out=0.
- Load in RESP, rst pulsed 1 cycle, then rvalid -> no wb_valid, FSM IDLE, in_ready=1, outputs zero.
- With MEM_MISALIGN_TRAP_EN: LW addr=0x402 -> dmem_req never asserted, wb_valid=1, misalign=1, regWrite_out=0; without the macro: request issued at 0x400.
